skew_ram_loader: RTL and testbench
==================================

# skew_ram_loader

Writer side of the systolic operand RAM banks. Accepts a row-major N×K operand matrix as a 16-bit valid/ready stream and fills N single-port operand RAM banks, one per array row, through their clk/en/we/addr/di ports. Each bank receives its row delayed by the row index, with zero padding, so the array feeder can read all banks in lock-step. Sits between the host/UART load path and the operand RAM banks.

## Interface
- N, 4, number of banks (array rows)
- K, 4, matrix columns (inner dimension)
- L, 16, bank depth in words; L >= N+K-1 is required
- AW, 4, bank address width; 2**AW >= L
- DW, 16, data width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- in_valid  in  1  stream word valid
- in_data  in  DW  stream word, row-major A[r][c]
- in_ready  out  1  loader accepts in_data this cycle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, load complete
- ram_en  out  N  per-bank enable, one-hot or zero
- ram_we  out  N  per-bank write enable, equals ram_en
- ram_addr  out  AW  shared bank address
- ram_di  out  DW  shared write data

## Operation
- Slot (r,a) for bank r in 0..N-1, address a in 0..L-1; visited bank-major, address-minor: (0,0),(0,1)…(0,L-1),(1,0)…(N-1,L-1).
- Slot is a data slot iff r <= a < r+K; it holds A[r][a-r]. All other slots are written 0.
- Traversal order consumes stream words in row-major order; no buffering.
- FSM: IDLE -> LOAD on start; LOAD -> DONE after slot (N-1,L-1) is issued; DONE -> IDLE next cycle.
- IDLE: in_ready=0, busy=0, no strobes. start with in_valid ignored.
- LOAD: in_ready = 1 only on a data slot. Data slot advances only on in_valid&&in_ready. Zero slot advances every cycle, no stream word consumed.
- start while busy is ignored. in_data outside LOAD is dropped (in_ready=0).
- Bank r's every address is written exactly once per load; previous contents fully overwritten.
- rst at any time: state IDLE, slot counters 0, all outputs 0; partially written banks left as is, no done pulse.

## Timing
- Reset values: in_ready=0, busy=0, done=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0.
- start accepted in cycle t -> busy=1 and first slot live from t+1.
- Slot issue in cycle t (handshake or zero slot) -> ram_en[r]=ram_we[r]=1, ram_addr=a, ram_di=word/0 registered, visible cycle t+1; RAM updates at end of t+1.
- in_ready is combinational from state/slot only, never from in_valid.
- Strobes deasserted in any cycle with no slot issued (stream stall).
- Minimum load time N*L issue cycles (64 default); each stall cycle adds one.
- done=1 in the cycle after the last write strobe; busy falls with done; start accepted again from the cycle after done.

## Structure
- Shared package: N, K, L, AW, DW constants and FSM state encoding (IDLE, LOAD, DONE), shared with the operand RAM and array feeder.
- One sub-module natural: skew_slot_counter — bank/address counters with advance input, outputs r, a, is_data_slot, last_slot.
- Top holds FSM, handshake and registered RAM write port.

## Test plan
- Reset then A = rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, in_valid held 1 -> bank0 addr0..3 = 1..4, addr4..15 = 0; bank1 addr0=0, addr1..4=5..8; bank3 addr0..2=0, addr3..6=13..16, rest 0; done after exactly 64 issue cycles + 1.
- Same matrix, in_valid toggled every other cycle -> identical bank contents; no strobe in stall cycles; in_ready low on all zero slots.
- start pulsed mid-load and in_valid high while IDLE -> ignored; no extra words consumed, no strobes in IDLE.
- rst asserted at slot (2,5) -> next cycle all outputs 0, state IDLE; fresh start then full load yields correct contents, single done.
- Preloaded banks with 0xFFFF, load K=4 matrix -> every non-data address reads 0, none 0xFFFF.
- Back-to-back loads: start in cycle after done -> accepted, second matrix fully replaces first.

Source files
------------

// File: rtl/skew_ram_loader_pkg.sv
// Shared constants for the systolic operand RAM path:
// matrix geometry, bank geometry and loader FSM encoding.
package skew_ram_loader_pkg;

   localparam int N  = 4;
   localparam int K  = 4;
   localparam int L  = 16;
   localparam int AW = 4;
   localparam int DW = 16;

   localparam int RW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/skew_ram_loader_slot_counter.sv
// Bank/address slot walker, bank-major and address-minor,
// flagging skewed data slots and the final slot of a load.
module skew_slot_counter
   import skew_ram_loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          adv_i,
   output logic [RW-1:0] r_o,
   output logic [AW-1:0] a_o,
   output logic          is_data_o,
   output logic          last_o
);

   localparam int CW = AW + 2;

   logic [RW-1:0] r_q, r_d;
   logic [AW-1:0] a_q, a_d;
   logic [CW-1:0] a_w, lo_w, hi_w;

   always_comb begin
      r_d = r_q;
      a_d = a_q;
      if (clr_i) begin
         r_d = '0;
         a_d = '0;
      end else if (adv_i) begin
         if (last_o) begin
            r_d = '0;
            a_d = '0;
         end else if (a_q == AW'(L - 1)) begin
            r_d = r_q + 1'b1;
            a_d = '0;
         end else begin
            a_d = a_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
         a_q <= '0;
      end else begin
         r_q <= r_d;
         a_q <= a_d;
      end
   end

   // Bank r holds its row in addresses r .. r+K-1.
   assign a_w  = CW'(a_q);
   assign lo_w = CW'(r_q);
   assign hi_w = CW'(r_q) + CW'(K);

   assign is_data_o = (a_w >= lo_w) && (a_w < hi_w);
   assign last_o    = (r_q == RW'(N - 1)) && (a_q == AW'(L - 1));
   assign r_o       = r_q;
   assign a_o       = a_q;

endmodule

// File: rtl/skew_ram_loader.sv
// Streams a row-major N x K matrix into N skewed operand RAM banks,
// zero-padding every slot outside each bank's row window.
module skew_ram_loader
   import skew_ram_loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  ram_en,
   output logic [N-1:0]  ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_di
);

   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic [N-1:0]  en_q, en_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] di_q, di_d;

   logic [RW-1:0] slot_r;
   logic [AW-1:0] slot_a;
   logic          is_data, is_last;
   logic          walking, issue;

   skew_slot_counter u_slot (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q != S_LOAD),
      .adv_i     (issue),
      .r_o       (slot_r),
      .a_o       (slot_a),
      .is_data_o (is_data),
      .last_o    (is_last)
   );

   // last_q marks the drain cycle where the final strobe is on the port.
   assign walking  = (state_q == S_LOAD) && !last_q;
   assign in_ready = walking && is_data;
   assign issue    = walking && (!is_data || in_valid);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      en_d    = '0;
      addr_d  = addr_q;
      di_d    = di_q;
      unique case (state_q)
         S_IDLE: begin
            last_d = 1'b0;
            if (start) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (last_q) begin
               state_d = S_DONE;
            end else if (issue) begin
               en_d   = N'(1) << slot_r;
               addr_d = slot_a;
               di_d   = is_data ? in_data : '0;
               last_d = is_last;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            last_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         last_q  <= 1'b0;
         en_q    <= '0;
         addr_q  <= '0;
         di_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         en_q    <= en_d;
         addr_q  <= addr_d;
         di_q    <= di_d;
      end
   end

   assign busy     = (state_q == S_LOAD);
   assign done     = (state_q == S_DONE);
   assign ram_en   = en_q;
   assign ram_we   = en_q;
   assign ram_addr = addr_q;
   assign ram_di   = di_q;

endmodule

// File: tb/tb_skew_ram_loader.sv
// Randomized scoreboard bench for skew_ram_loader with a bank image
// reference built from the skew rule A[r][a-r] on r <= a < r+K.
module tb_skew_ram_loader;
   import skew_ram_loader_pkg::*;

   logic          clk = 1'b0;
   logic          rst, start, in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready, busy, done;
   logic [N-1:0]  ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_di;

   skew_ram_loader dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_di   (ram_di)
   );

   always #5 clk = ~clk;

   typedef struct {
      int        r;
      int        a;
      logic [15:0] d;
   } wr_t;

   wr_t         exp_q[$];
   logic [15:0] mem[N][L];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          last_wr_cyc = -10;
   int          wr_seen = 0;
   int          done_cnt = 0;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every strobe pops one expected write; also emulates the banks.
   always @(negedge clk) begin
      if (ram_en != '0) begin
         wr_seen++;
         if (exp_q.size() == 0) begin
            check("stray_write", ram_en, 0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_en", ram_en, 64'(1) << e.r);
            check("wr_we", ram_we, ram_en);
            check("wr_addr", ram_addr, e.a);
            check("wr_data", ram_di, e.d);
         end
         for (int b = 0; b < N; b++)
            if (ram_en[b]) mem[b][ram_addr] = ram_di;
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         check("done_gap", cyc - last_wr_cyc, 1);
         check("busy_at_done", busy, 0);
      end
      cyc++;
   end

   task automatic run_load(input int mode, input int abort_n, input bit fixed);
      logic [15:0] A[N][K];
      logic [15:0] img[N][L];
      int pos, idx, last_k, d0;
      bit hs, got, aborted, dslot;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < K; c++)
            A[r][c] = fixed ? 16'(r * K + c + 1) : 16'($urandom);
      for (int r = 0; r < N; r++)
         for (int a = 0; a < L; a++) begin
            img[r][a] = (a >= r && a < r + K) ? A[r][a - r] : 16'h0;
            exp_q.push_back('{r, a, img[r][a]});
         end
      wr_seen = 0;
      d0 = done_cnt;
      @(negedge clk); #2;
      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      pos = 0; idx = 0; last_k = -1; got = 0; aborted = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #2;
         start = (mode == 2 && (k == 10 || k == 40));
         if (abort_n >= 0 && wr_seen >= abort_n) begin
            rst = 1'b1; start = 1'b0; in_valid = 1'b0;
            aborted = 1;
            break;
         end
         if (done_cnt != d0) begin
            got = 1;
            check("done_cycle", k, last_k + 2);
            in_valid = 1'b0;
            start = 1'b0;
            break;
         end
         case (mode)
            1: in_valid = k[0];
            3: in_valid = 1'($urandom_range(0, 1));
            default: in_valid = 1'b1;
         endcase
         in_data = (idx < N * K) ? A[idx / K][idx % K] : 16'($urandom);
         #1;
         dslot = (pos < N * L) && (pos % L >= pos / L) && (pos % L < pos / L + K);
         check("busy", busy, 1);
         check("in_ready", in_ready, dslot);
         hs = in_valid && in_ready;
         if (pos < N * L && (hs || !dslot)) begin
            pos++;
            last_k = k;
         end
         if (hs) idx++;
      end
      if (aborted) begin
         @(posedge clk); #1;
         check("rst_in_ready", in_ready, 0);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_ram_en", ram_en, 0);
         check("rst_ram_we", ram_we, 0);
         check("rst_ram_addr", ram_addr, 0);
         check("rst_ram_di", ram_di, 0);
         exp_q.delete();
         @(negedge clk); #2;
         rst = 1'b0;
         repeat (4) @(negedge clk);
         check("no_done_after_rst", done_cnt, d0);
      end else begin
         check("got_done", got, 1);
         if (mode == 0) check("load_len", last_k, N * L - 1);
         check("words_used", idx, N * K);
         check("queue_drained", exp_q.size(), 0);
         for (int r = 0; r < N; r++)
            for (int a = 0; a < L; a++)
               check($sformatf("bank%0d_a%0d", r, a), mem[r][a], img[r][a]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < N; b++)
         for (int a = 0; a < L; a++)
            mem[b][a] = 16'hFFFF;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_ram_en", ram_en, 0);
      check("reset_ram_we", ram_we, 0);
      check("reset_ram_addr", ram_addr, 0);
      check("reset_ram_di", ram_di, 0);
      @(negedge clk); #2;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #2;
         in_valid = 1'b1;
         in_data = 16'($urandom);
         #1;
         check("idle_in_ready", in_ready, 0);
         check("idle_busy", busy, 0);
      end
      in_valid = 1'b0;
      run_load(0, -1, 1'b1);
      run_load(1, -1, 1'b1);
      run_load(2, -1, 1'b0);
      run_load(0, 37, 1'b0);
      run_load(3, -1, 1'b0);
      run_load(0, -1, 1'b0);
      repeat (4) @(negedge clk);
      check("done_pulses", done_cnt, 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
